eth_upload_sched: RTL
=====================

# eth_upload_sched

Upload-path scheduler in front of the Ethernet transmit engine. It shares the single upload channel (`tx_data_en`/`tx_data_len` plus the upload RAM read port) between two frame sources, each owning its own 512×32 payload RAM. It arbitrates round-robin, launches one frame per grant and steers the engine's RAM read port to the granted source. It holds the channel until the engine reports completion or a watchdog expires, then enforces an inter-frame gap.

## Interface
- `TIMEOUT_CYC`, 65535: WAIT-state watchdog length in clocks, range 2..65535.
- `GAP_CYC`, 12: idle clocks forced between frames, range 1..255.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `src_req`  in  2  level request per source; bit i belongs to source i.
- `src0_len`  in  9  source 0 frame length in 32-bit words, stable while `src_req[0]` is high.
- `src1_len`  in  9  source 1 frame length in 32-bit words.
- `src_grant`  out  2  one-hot; marks the source that owns the channel.
- `src_done`  out  2  one-clock pulse on the granted bit when its frame finishes or is dropped.
- `src_err`  out  2  one-clock pulse, coincident with `src_done`, on timeout or zero length.
- `src0_rdaddr`  out  9  read address to source 0 RAM.
- `src0_rddata`  in  32  read data from source 0 RAM.
- `src1_rdaddr`  out  9  read address to source 1 RAM.
- `src1_rddata`  in  32  read data from source 1 RAM.
- `tx_data_en`  out  1  one-clock frame-start pulse to the Ethernet engine.
- `tx_data_len`  out  9  frame length; valid on the `tx_data_en` pulse and held until the next launch.
- `upload_ram_rdaddr`  in  9  read address from the Ethernet engine.
- `upload_ram_rddata`  out  32  read data returned to the Ethernet engine.
- `tx_done`  in  1  one-clock pulse from the engine at end of frame.
- `sched_busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE → START → WAIT → GAP → IDLE.
- **IDLE**
  - Samples `src_req`.
  - If only one bit is set, that source wins. If both are set, the winner is the source not equal to `last_src`.
  - Winner is latched in `cur_src`, and its length in `tx_data_len`.
  - Goes to START.
  - Zero length: the winner is not launched. `src_done` and `src_err` pulse for one clock, `last_src` updates, and the FSM goes to GAP. No `src_grant` and no `tx_data_en` are issued.
- **START**
  - One clock: `tx_data_en`=1 and `src_grant[cur_src]`=1.
  - Watchdog counter cleared. Goes to WAIT.
- **WAIT**
  - `src_grant` held and watchdog counting.
  - On `tx_done`: go to GAP, pulse `src_done[cur_src]`, `last_src`←`cur_src`.
  - If the watchdog reaches `TIMEOUT_CYC`-1 with no `tx_done`: same as above, plus `src_err[cur_src]`.
  - `tx_done` in any other state is ignored.
- **GAP**
  - `src_grant`=0. Counts `GAP_CYC` clocks, then goes to IDLE.
- **Read steering** (combinational, zero added latency)
  - `srcX_rdaddr` = `upload_ram_rdaddr` when `src_grant[X]`, else 0.
  - `upload_ram_rddata` = `src0_rddata` when `src_grant[0]`, `src1_rddata` when `src_grant[1]`, else 0.
  - The RAM read latency is the source RAM's own; the engine accounts for it.
- **Request lifetime**
  - A requester drops `src_req` on its `src_done`.
  - If `src_req` is still high when the FSM returns to IDLE, it is a new frame request.
  - A request that falls before being granted is simply not served.
- **Lengths**
  - Passed through unmodified, 1..511 words.
  - Counters are sized to their parameters. No arithmetic is done on length.

## Timing
- Reset (asynchronous, `rst_n`=0), all outputs 0:
  - `src_grant`, `src_done`, `src_err`, `tx_data_en`, `tx_data_len`, `srcX_rdaddr`, `upload_ram_rddata`, `sched_busy`.
  - State is IDLE and `last_src`=1, so source 0 wins the first tie.
- Reset mid-frame aborts the frame silently: no `src_done`.
- Launch timing: request high in IDLE at clock N → START at N+1 (`tx_data_en`, `src_grant` high) → WAIT from N+2.
- Completion timing: `tx_done` at WAIT clock M:
  - `src_done` high at M+1, with `src_grant` low at M+1.
  - GAP lasts M+1..M+`GAP_CYC`; IDLE at M+`GAP_CYC`+1.
  - Next `tx_data_en` no earlier than M+`GAP_CYC`+2.
- `tx_done` coinciding with the watchdog terminal count counts as success: no `src_err`.
- `tx_done` during START is ignored; the frame then ends by `tx_done` in WAIT or by timeout.
- `sched_busy` is registered from state; high from START (or from GAP for a zero-length drop) through the last GAP clock.

## Test plan
- Single frame:
  - Stimulus: `src_req`=01, `src0_len`=100, `tx_done` 50 clocks after `tx_data_en`, `GAP_CYC`=12.
  - Response: one `tx_data_en` with `tx_data_len`=100; `src_grant`=01 for 51 clocks; `src_done`=01 one clock; next launch ≥13 clocks later.
- Round-robin:
  - Stimulus: both requests held high with lengths 10 and 20; engine answers each frame.
  - Response: launches alternate src0, src1, src0, src1 with lengths 10, 20, 10, 20; never two consecutive launches to one source.
- Read steering:
  - Stimulus: `src1_rddata`=0xA5A5_0000+addr while src1 is granted; engine sweeps addr 0..15.
  - Response: `src1_rdaddr` follows `upload_ram_rdaddr`; `src0_rdaddr`=0; `upload_ram_rddata` matches source 1.
- Timeout:
  - Stimulus: `TIMEOUT_CYC`=64, `tx_done` never pulses.
  - Response: `src_done` and `src_err` pulse exactly 64 clocks after WAIT entry; scheduler recovers and serves the other source.
- Zero length and stray done:
  - Stimulus: `src0_len`=0 with `src_req`=01, plus a `tx_done` pulse while IDLE.
  - Response: no `tx_data_en`; `src_done[0]` and `src_err[0]` pulse once; stray `tx_done` has no effect.
- Reset mid-frame:
  - Stimulus: `rst_n` low during WAIT.
  - Response: all outputs 0 immediately; no `src_done`; after release the first tie goes to source 0.

Source files
------------

// File: rtl/eth_upload_sched_if.sv
// Channel bundle shared by the two frame sources, the upload scheduler and the Ethernet engine.
// master is the scheduler's view; slave is the view of the sources and engine around it.
interface eth_upload_sched_if;
    logic [1:0]  src_req;
    logic [8:0]  src0_len;
    logic [8:0]  src1_len;
    logic [1:0]  src_grant;
    logic [1:0]  src_done;
    logic [1:0]  src_err;
    logic [8:0]  src0_rdaddr;
    logic [31:0] src0_rddata;
    logic [8:0]  src1_rdaddr;
    logic [31:0] src1_rddata;
    logic        tx_data_en;
    logic [8:0]  tx_data_len;
    logic [8:0]  upload_ram_rdaddr;
    logic [31:0] upload_ram_rddata;
    logic        tx_done;
    logic        sched_busy;

    modport master (
        input  src_req, src0_len, src1_len, src0_rddata, src1_rddata,
        input  upload_ram_rdaddr, tx_done,
        output src_grant, src_done, src_err, src0_rdaddr, src1_rdaddr,
        output tx_data_en, tx_data_len, upload_ram_rddata, sched_busy
    );

    modport slave (
        output src_req, src0_len, src1_len, src0_rddata, src1_rddata,
        output upload_ram_rdaddr, tx_done,
        input  src_grant, src_done, src_err, src0_rdaddr, src1_rdaddr,
        input  tx_data_en, tx_data_len, upload_ram_rddata, sched_busy
    );
endinterface

// File: rtl/eth_upload_sched.sv
// Round-robin scheduler sharing one Ethernet upload channel between two frame sources.
// Launches one frame per grant, steers the engine's RAM reads, and applies a watchdog and inter-frame gap.
module eth_upload_sched #(
    parameter int TIMEOUT_CYC = 65535,
    parameter int GAP_CYC     = 12
) (
    input logic                clk,
    input logic                rst_n,
    eth_upload_sched_if.master bus
);
    localparam int WD_W  = $clog2(TIMEOUT_CYC);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t            state, state_n;
    logic              cur_src, cur_src_n;
    logic              last_src, last_src_n;
    logic [8:0]        len_q, len_n;
    logic [1:0]        done_q, done_n;
    logic [1:0]        err_q, err_n;
    logic [WD_W-1:0]   wd_cnt, wd_cnt_n;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;
    logic              winner;
    logic [8:0]        winner_len;
    logic              wd_expired;
    logic [1:0]        grant;

    // On a tie the source that did not go last wins.
    always_comb begin
        case (bus.src_req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            default: winner = ~last_src;
        endcase
        winner_len = winner ? bus.src1_len : bus.src0_len;
    end

    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_n    = state;
        cur_src_n  = cur_src;
        last_src_n = last_src;
        len_n      = len_q;
        done_n     = 2'b00;
        err_n      = 2'b00;
        wd_cnt_n   = wd_cnt;
        gap_cnt_n  = gap_cnt;
        case (state)
            IDLE: begin
                if (bus.src_req != 2'b00) begin
                    cur_src_n = winner;
                    // A zero-length frame is dropped without touching the engine.
                    if (winner_len == 9'd0) begin
                        done_n     = {winner, ~winner};
                        err_n      = {winner, ~winner};
                        last_src_n = winner;
                        gap_cnt_n  = '0;
                        state_n    = GAP;
                    end else begin
                        len_n   = winner_len;
                        state_n = START;
                    end
                end
            end
            START: begin
                wd_cnt_n = '0;
                state_n  = WAIT;
            end
            WAIT: begin
                if (bus.tx_done || wd_expired) begin
                    done_n     = {cur_src, ~cur_src};
                    err_n      = bus.tx_done ? 2'b00 : {cur_src, ~cur_src};
                    last_src_n = cur_src;
                    gap_cnt_n  = '0;
                    state_n    = GAP;
                end else begin
                    wd_cnt_n = wd_cnt + WD_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // last_src resets to 1 so source 0 takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_src  <= 1'b0;
            last_src <= 1'b1;
            len_q    <= 9'd0;
            done_q   <= 2'b00;
            err_q    <= 2'b00;
            wd_cnt   <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_n;
            cur_src  <= cur_src_n;
            last_src <= last_src_n;
            len_q    <= len_n;
            done_q   <= done_n;
            err_q    <= err_n;
            wd_cnt   <= wd_cnt_n;
            gap_cnt  <= gap_cnt_n;
        end
    end

    assign grant = ((state == START) || (state == WAIT)) ? {cur_src, ~cur_src} : 2'b00;

    assign bus.src_grant   = grant;
    assign bus.src_done    = done_q;
    assign bus.src_err     = err_q;
    assign bus.tx_data_en  = (state == START);
    assign bus.tx_data_len = len_q;
    assign bus.sched_busy  = (state != IDLE);

    // Read steering is purely combinational so the engine sees the source RAM's own latency.
    assign bus.src0_rdaddr = grant[0] ? bus.upload_ram_rdaddr : 9'd0;
    assign bus.src1_rdaddr = grant[1] ? bus.upload_ram_rdaddr : 9'd0;
    assign bus.upload_ram_rddata = grant[0] ? bus.src0_rddata :
                                   grant[1] ? bus.src1_rddata : 32'd0;
endmodule
